// File: rtl/grid_mover.sv
// grid_mover: steps a position around a pixel grid one CELL at a time in
// response to direction switches. A press moves immediately, then the block
// sits in HOP for HOP_CYCLES cycles. If the switch is still held it waits
// REPEAT_DELAY cycles in HOLD and repeats the move. Moves that would leave
// the 0..X_MAX / 0..Y_MAX box are rejected with a one-cycle blocked strobe.
module grid_mover #(
  parameter int CELL         = 32,
  parameter int W            = 10,
  parameter int X_MAX        = 608,
  parameter int Y_MAX        = 448,
  parameter int START_X      = 320,
  parameter int START_Y      = 448,
  parameter int HOP_CYCLES   = 4,
  parameter int REPEAT_DELAY = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic         enable,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic [1:0]   direction,
  output logic         hopping,
  output logic         move_pulse,
  output logic         blocked_pulse
);

  // Counter widths only need to hold LOAD values (HOP_CYCLES-1, REPEAT_DELAY-1).
  localparam int HCW = (HOP_CYCLES   > 1) ? $clog2(HOP_CYCLES)   : 1;
  localparam int RCW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;

  localparam logic [HCW-1:0] HOP_LOAD = HCW'(HOP_CYCLES - 1);
  localparam logic [RCW-1:0] REP_LOAD = RCW'(REPEAT_DELAY - 1);

  // Bound checks run one bit wider than the coordinates so pos + CELL
  // cannot wrap past the top of the W-bit range.
  localparam logic [W:0]   CELL_WIDE  = (W+1)'(CELL);
  localparam logic [W:0]   XMAX_WIDE  = (W+1)'(X_MAX);
  localparam logic [W:0]   YMAX_WIDE  = (W+1)'(Y_MAX);
  localparam logic [W-1:0] CELL_STEP  = W'(CELL);

  // Heading codes double as the bit index into req.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOP  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     req_q;
  logic [HCW-1:0] hop_cnt_q, hop_cnt_d;
  logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
  logic [1:0]     held_q, held_d;
  logic [W-1:0]   pos_x_d, pos_y_d;
  logic [1:0]     dir_d;
  logic           move_d, blocked_d;

  logic [3:0]     rise;
  logic           any_rise;
  logic           other_rise;
  logic           held_active;
  logic [1:0]     sel_dir;
  logic [1:0]     try_dir;
  logic           legal;
  logic [W-1:0]   new_x, new_y;
  logic           attempt;

  assign rise        = req & ~req_q;
  assign any_rise    = |rise;
  assign held_active = req[held_q];
  assign other_rise  = |(rise & ~(4'b0001 << held_q));
  assign hopping     = (state_q == S_HOP);

  // Fixed-priority pick among simultaneous presses: up > left > right > down.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    sel_dir = DIR_DOWN;
    if (rise[0])      sel_dir = DIR_UP;
    else if (rise[1]) sel_dir = DIR_LEFT;
    else if (rise[2]) sel_dir = DIR_RIGHT;
  end

  // A repeat from HOLD retries the held heading; anything else uses the new press.
  assign try_dir = (state_q == S_HOLD && !other_rise) ? held_q : sel_dir;

  // Legality and destination of a one-cell step in heading try_dir.
  always_comb begin
    legal = 1'b0;
    new_x = pos_x;
    new_y = pos_y;
    unique case (try_dir)
      DIR_UP: begin
        legal = {1'b0, pos_y} >= CELL_WIDE;
        new_y = pos_y - CELL_STEP;
      end
      DIR_LEFT: begin
        legal = {1'b0, pos_x} >= CELL_WIDE;
        new_x = pos_x - CELL_STEP;
      end
      DIR_RIGHT: begin
        legal = ({1'b0, pos_x} + CELL_WIDE) <= XMAX_WIDE;
        new_x = pos_x + CELL_STEP;
      end
      DIR_DOWN: begin
        legal = ({1'b0, pos_y} + CELL_WIDE) <= YMAX_WIDE;
        new_y = pos_y + CELL_STEP;
      end
    endcase
  end

  // Next-state and next-output logic for IDLE / HOP / HOLD.
  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x;
    pos_y_d   = pos_y;
    dir_d     = direction;
    held_d    = held_q;
    hop_cnt_d = hop_cnt_q;
    rep_cnt_d = rep_cnt_q;
    move_d    = 1'b0;
    blocked_d = 1'b0;
    attempt   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable && any_rise) attempt = 1'b1;
      end

      S_HOP: begin
        // Presses during a hop are dropped; only the held switch matters here.
        if (hop_cnt_q == '0) begin
          if (held_active) begin
            state_d   = S_HOLD;
            rep_cnt_d = REP_LOAD;
          end else begin
            state_d   = S_IDLE;
          end
        end else begin
          hop_cnt_d = hop_cnt_q - 1'b1;
        end
      end

      S_HOLD: begin
        if (other_rise) begin
          // A fresh press on another switch is handled exactly as from IDLE.
          if (enable) attempt = 1'b1;
          else        state_d = S_IDLE;
        end else if (!held_active) begin
          state_d = S_IDLE;
        end else if (rep_cnt_q == '0) begin
          // With enable low the repeat waits here until enable returns.
          if (enable) attempt = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (attempt) begin
      dir_d = try_dir;
      if (legal) begin
        pos_x_d   = new_x;
        pos_y_d   = new_y;
        move_d    = 1'b1;
        held_d    = try_dir;
        hop_cnt_d = HOP_LOAD;
        state_d   = S_HOP;
      end else begin
        blocked_d = 1'b1;
        state_d   = S_IDLE;
      end
    end
  end

  // State, position and strobe registers; reset also primes the edge detector.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    req_q <= req;
    if (reset) begin
      state_q       <= S_IDLE;
      pos_x         <= W'(START_X);
      pos_y         <= W'(START_Y);
      direction     <= DIR_UP;
      held_q        <= DIR_UP;
      hop_cnt_q     <= '0;
      rep_cnt_q     <= '0;
      move_pulse    <= 1'b0;
      blocked_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_x         <= pos_x_d;
      pos_y         <= pos_y_d;
      direction     <= dir_d;
      held_q        <= held_d;
      hop_cnt_q     <= hop_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      move_pulse    <= move_d;
      blocked_pulse <= blocked_d;
    end
  end

endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover: directed scenarios followed by random switch activity, with
// every cycle compared against a cycle-count based behavioural model.
module tb_grid_mover;

  localparam int CELL         = 32;
  localparam int W            = 10;
  localparam int X_MAX        = 608;
  localparam int Y_MAX        = 448;
  localparam int START_X      = 320;
  localparam int START_Y      = 448;
  localparam int HOP_CYCLES   = 4;
  localparam int REPEAT_DELAY = 8;

  localparam int M_IDLE = 0;
  localparam int M_HOP  = 1;
  localparam int M_HOLD = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic         enable = 1'b1;
  logic [W-1:0] pos_x, pos_y;
  logic [1:0]   direction;
  logic         hopping, move_pulse, blocked_pulse;

  int total = 0;
  int bad   = 0;

  // Model state: absolute cycle numbers instead of down-counters.
  int         n = 0;
  int         m_x, m_y, m_dir, m_held, m_mode, m_move_at, m_rep_at;
  bit         m_mp, m_bp;
  logic [3:0] m_prev;

  grid_mover #(
    .CELL(CELL), .W(W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .START_X(START_X), .START_Y(START_Y),
    .HOP_CYCLES(HOP_CYCLES), .REPEAT_DELAY(REPEAT_DELAY)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .enable(enable),
    .pos_x(pos_x), .pos_y(pos_y), .direction(direction),
    .hopping(hopping), .move_pulse(move_pulse), .blocked_pulse(blocked_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, n);
    end
  endtask

  // Try one step in heading d from the model position.
  task automatic model_attempt(input int d);
    int nx, ny;
    nx = m_x;
    ny = m_y;
    case (d)
      0: ny = ny - CELL;
      1: nx = nx - CELL;
      2: nx = nx + CELL;
      default: ny = ny + CELL;
    endcase
    m_dir = d;
    if (nx >= 0 && nx <= X_MAX && ny >= 0 && ny <= Y_MAX) begin
      m_x = nx; m_y = ny; m_mp = 1'b1;
      m_mode = M_HOP; m_move_at = n; m_held = d;
    end else begin
      m_bp = 1'b1; m_mode = M_IDLE;
    end
  endtask

  task automatic model_press(input logic [3:0] rise);
    int d;
    d = 3;
    for (int i = 3; i >= 0; i--) if (rise[i]) d = i;
    model_attempt(d);
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    logic [3:0] rise;
    n++;
    m_mp = 1'b0;
    m_bp = 1'b0;
    rise = req & ~m_prev;
    m_prev = req;
    if (reset) begin
      m_x = START_X; m_y = START_Y; m_dir = 0; m_mode = M_IDLE;
      return;
    end
    case (m_mode)
      M_HOP: begin
        if (n == m_move_at + HOP_CYCLES) begin
          if (req[m_held]) begin
            m_mode = M_HOLD;
            m_rep_at = n + REPEAT_DELAY;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      M_HOLD: begin
        if ((rise & ~(4'b0001 << m_held)) != 4'b0000) begin
          if (enable) model_press(rise);
          else        m_mode = M_IDLE;
        end else if (!req[m_held]) begin
          m_mode = M_IDLE;
        end else if (n >= m_rep_at && enable) begin
          model_attempt(m_held);
        end
      end
      default: begin
        if (enable && rise != 4'b0000) model_press(rise);
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pos_x",     pos_x,         m_x);
    check("pos_y",     pos_y,         m_y);
    check("direction", direction,     m_dir);
    check("hopping",   hopping,       (m_mode == M_HOP));
    check("move",      move_pulse,    m_mp);
    check("blocked",   blocked_pulse, m_bp);
    check("exclusive", move_pulse & blocked_pulse, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int cnt;
    m_prev = 4'b0000;
    m_x = START_X; m_y = START_Y; m_dir = 0; m_mode = M_IDLE;
    m_held = 0; m_move_at = 0; m_rep_at = 0;

    // Reset state
    do_reset();
    check("rst_x", pos_x, 320);
    check("rst_y", pos_y, 448);
    check("rst_dir", direction, 0);
    check("rst_hop", hopping, 0);

    // Single up press: move next cycle, hopping for 4 cycles
    req = 4'b0001;
    tick();
    check("up_y", pos_y, 416);
    check("up_dir", direction, 0);
    check("up_pulse", move_pulse, 1);
    req = 4'b0000;
    cnt = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      cnt += hopping;
    end
    check("hop_len", cnt, 4);

    // Down at the bottom edge is blocked
    do_reset();
    req = 4'b1000;
    tick();
    check("blk_pulse", blocked_pulse, 1);
    check("blk_y", pos_y, 448);
    check("blk_dir", direction, 3);
    tick();
    check("blk_once", blocked_pulse, 0);
    req = 4'b0000;
    tick();

    // Left and right together: left wins
    do_reset();
    req = 4'b0110;
    tick();
    check("pri_x", pos_x, 288);
    check("pri_dir", direction, 1);
    req = 4'b0000;
    for (int k = 0; k < 6; k++) tick();

    // Held left auto-repeats at t+1, t+13, t+25
    do_reset();
    req = 4'b0010;
    cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      cnt += move_pulse;
      if (k == 1 || k == 13 || k == 25) begin
        check("rpt_pulse", move_pulse, 1);
        check("rpt_x", pos_x, 320 - CELL * ((k - 1) / 12 + 1));
      end
    end
    check("rpt_count", cnt, 3);
    req = 4'b0000;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt += move_pulse;
    end
    check("rpt_stop", cnt, 0);
    check("rpt_final_x", pos_x, 224);

    // Switch held through reset release gives no move
    reset = 1'b1;
    req = 4'b0001;
    tick();
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      cnt += move_pulse;
    end
    check("thru_rst_moves", cnt, 0);
    check("thru_rst_y", pos_y, 448);
    req = 4'b0000;
    tick();
    req = 4'b0001;
    tick();
    check("repress_pulse", move_pulse, 1);
    check("repress_y", pos_y, 416);
    req = 4'b0000;
    for (int k = 0; k < 6; k++) tick();

    // Reset during HOP aborts it
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    check("mid_hop", hopping, 1);
    reset = 1'b1;
    tick();
    check("abort_x", pos_x, 320);
    check("abort_y", pos_y, 448);
    check("abort_hop", hopping, 0);
    check("abort_pulse", move_pulse, 0);
    reset = 1'b0;
    req = 4'b0000;
    tick();

    // Random switch activity against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) req[$urandom_range(3)] = ~req[$urandom_range(3)];
      if ($urandom_range(7) == 0) req[$urandom_range(3)] = 1'b0;
      enable = ($urandom_range(15) != 0);
      reset  = ($urandom_range(299) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
